// File: rtl/rle_kernel_param_if.sv
// Stream edges around the RLE kernel: an avail/read input edge and a write/afull output edge.
// The kernel connects through the slave modport; the neighbouring FIFOs/bench use master.
interface rle_kernel_param_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]             input_S1;
    logic                              avail_S1;
    logic                              read_S1;
    logic [COUNT_WIDTH+DATA_WIDTH-1:0] output_S2;
    logic                              write_S2;
    logic                              afull_S2;

    modport master (
        output input_S1,
        output avail_S1,
        input  read_S1,
        input  output_S2,
        input  write_S2,
        output afull_S2
    );

    modport slave (
        input  input_S1,
        input  avail_S1,
        output read_S1,
        output output_S2,
        output write_S2,
        input  afull_S2
    );
endinterface

// File: rtl/rle_kernel_param.sv
// Parametrised streaming run-length encoder: emits {run_count, run_value} words with
// run saturation, explicit flush and an optional idle-timeout auto-flush.
module rle_kernel_param #(
    parameter int DATA_WIDTH   = 16,
    parameter int COUNT_WIDTH  = 8,
    parameter int IDLE_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    output logic                busy,
    rle_kernel_param_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] MAX_RUN   = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [15:0]            IDLE_LIM  = 16'(IDLE_TIMEOUT);
    localparam bit                     IDLE_EN   = (IDLE_TIMEOUT != 0);

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_run_value;
    logic [COUNT_WIDTH-1:0]  r_run_count;
    logic [15:0]             r_idle_cnt;
    logic                    r_flush_pend;

    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   w_value_nxt;
    logic [COUNT_WIDTH-1:0]  w_count_nxt;
    logic [15:0]             w_idle_nxt;
    logic                    w_pend_nxt;
    logic                    w_read;
    logic                    w_write;
    logic                    w_timeout;
    logic                    w_extend;

    assign w_timeout = IDLE_EN && (r_idle_cnt == IDLE_LIM);
    assign w_extend  = (bus.input_S1 == r_run_value) && (r_run_count < MAX_RUN);

    // State and run registers; reset discards any held run without emitting it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_EMPTY;
            r_run_value  <= '0;
            r_run_count  <= '0;
            r_idle_cnt   <= 16'd0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_run_value  <= w_value_nxt;
            r_run_count  <= w_count_nxt;
            r_idle_cnt   <= w_idle_nxt;
            r_flush_pend <= w_pend_nxt;
        end
    end

    // Next-state and handshake decode; RUN branches are in strict priority order.
    always_comb begin
        w_state_nxt = r_state;
        w_value_nxt = r_run_value;
        w_count_nxt = r_run_count;
        w_idle_nxt  = r_idle_cnt;
        w_pend_nxt  = r_flush_pend;
        w_read      = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (bus.avail_S1) begin
                    w_read      = 1'b1;
                    w_value_nxt = bus.input_S1;
                    w_count_nxt = COUNT_ONE;
                    w_idle_nxt  = 16'd0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_RUN: begin
                if (flush || r_flush_pend || w_timeout) begin
                    if (!bus.afull_S2) begin
                        w_write     = 1'b1;
                        w_pend_nxt  = 1'b0;
                        w_idle_nxt  = 16'd0;
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_pend_nxt  = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end else if (bus.avail_S1) begin
                    if (w_extend) begin
                        w_read      = 1'b1;
                        w_count_nxt = r_run_count + COUNT_ONE;
                        w_idle_nxt  = 16'd0;
                    end else if (!bus.afull_S2) begin
                        // Terminating word is consumed in the same cycle the old run is written.
                        w_write     = 1'b1;
                        w_read      = 1'b1;
                        w_value_nxt = bus.input_S1;
                        w_count_nxt = COUNT_ONE;
                        w_idle_nxt  = 16'd0;
                    end else begin
                        w_read = 1'b0;
                    end
                end else begin
                    if (r_idle_cnt != IDLE_LIM) begin
                        w_idle_nxt = r_idle_cnt + 16'd1;
                    end else begin
                        w_idle_nxt = r_idle_cnt;
                    end
                end
            end
            ST_FLUSH: begin
                if (!bus.afull_S2) begin
                    w_write     = 1'b1;
                    w_pend_nxt  = 1'b0;
                    w_idle_nxt  = 16'd0;
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_pend_nxt  = 1'b0;
                w_idle_nxt  = 16'd0;
            end
        endcase
    end

    // Handshakes are forced low while reset is asserted, even if a word is offered.
    assign bus.read_S1   = w_read & rst;
    assign bus.write_S2  = w_write & rst;
    assign bus.output_S2 = {r_run_count, r_run_value};
    assign busy          = (r_state != ST_EMPTY);

endmodule

// File: tb/tb_rle_kernel_param.sv
// Directed bench for rle_kernel_param: two instances (no timeout / timeout 8), COUNT_WIDTH=4.
module tb_rle_kernel_param;

    localparam int DW = 16;
    localparam int CW = 4;

    logic clk;
    logic rst;
    logic flush_a;
    logic flush_b;
    logic busy_a;
    logic busy_b;
    int   n_vec;
    int   n_miss;
    int   hit_k;

    rle_kernel_param_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) ifa ();
    rle_kernel_param_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) ifb ();

    rle_kernel_param #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .IDLE_TIMEOUT(0)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_a),
        .busy  (busy_a),
        .bus   (ifa)
    );

    rle_kernel_param #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .IDLE_TIMEOUT(8)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_b),
        .busy  (busy_b),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic av, input logic [DW-1:0] d, input logic fl, input logic af);
        ifa.avail_S1 = av;
        ifa.input_S1 = d;
        flush_a      = fl;
        ifa.afull_S2 = af;
    endtask

    // Drive one cycle on dut_a and check read/write (and output word when a write is expected).
    task automatic cyc_a(input string tag, input logic av, input logic [DW-1:0] d, input logic fl,
                         input logic af, input logic exp_rd, input logic exp_wr,
                         input logic [CW+DW-1:0] exp_out);
        drive_a(av, d, fl, af);
        @(negedge clk);
        chk({tag, ".rd"}, 32'(ifa.read_S1), 32'(exp_rd));
        chk({tag, ".wr"}, 32'(ifa.write_S2), 32'(exp_wr));
        if (exp_wr) chk({tag, ".out"}, 32'(ifa.output_S2), 32'(exp_out));
        tick();
    endtask

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        rst     = 1'b0;
        drive_a(1'b1, 16'h0005, 1'b0, 1'b0);
        ifb.avail_S1 = 1'b0;
        ifb.input_S1 = 16'h0000;
        ifb.afull_S2 = 1'b0;
        flush_b      = 1'b0;

        // Reset state with a word offered: handshakes must stay low.
        @(negedge clk);
        chk("rst.rd",   32'(ifa.read_S1),   32'd0);
        chk("rst.wr",   32'(ifa.write_S2),  32'd0);
        chk("rst.out",  32'(ifa.output_S2), 32'd0);
        chk("rst.busy", 32'(busy_a),        32'd0);
        tick();
        rst = 1'b1;

        // 5,5,5,7,7 then flush.
        cyc_a("t1.w0", 1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 1'b0, 20'h0);
        cyc_a("t1.w1", 1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 1'b0, 20'h0);
        cyc_a("t1.w2", 1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 1'b0, 20'h0);
        cyc_a("t1.w3", 1'b1, 16'd7, 1'b0, 1'b0, 1'b1, 1'b1, 20'h30005);
        cyc_a("t1.w4", 1'b1, 16'd7, 1'b0, 1'b0, 1'b1, 1'b0, 20'h0);
        cyc_a("t1.fl", 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 20'h20007);
        drive_a(1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1.busy", 32'(busy_a), 32'd0);
        tick();

        // Saturation: 18 x 0xAA splits into {15,AA} and {3,AA}.
        for (int i = 1; i <= 18; i++) begin
            cyc_a("t2.sat", 1'b1, 16'h00AA, 1'b0, 1'b0, 1'b1, (i == 16), 20'hF00AA);
        end
        cyc_a("t2.fl", 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 20'h300AA);

        // Backpressure on a run-terminating word.
        cyc_a("t3.w1", 1'b1, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, 20'h0);
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 16'd2, 1'b0, 1'b1);
            @(negedge clk);
            chk("t3.stall.rd",  32'(ifa.read_S1),   32'd0);
            chk("t3.stall.wr",  32'(ifa.write_S2),  32'd0);
            chk("t3.stall.reg", 32'(ifa.output_S2), 32'h10001);
            tick();
        end
        cyc_a("t3.rel", 1'b1, 16'd2, 1'b0, 1'b0, 1'b1, 1'b1, 20'h10001);
        cyc_a("t3.fl",  1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 20'h10002);

        // Flush under afull, with avail held high throughout.
        for (int i = 0; i < 4; i++) begin
            cyc_a("t5.fill", 1'b1, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0, 20'h0);
        end
        cyc_a("t5.req",  1'b1, 16'd3, 1'b1, 1'b1, 1'b0, 1'b0, 20'h0);
        drive_a(1'b1, 16'd3, 1'b0, 1'b1);
        @(negedge clk);
        chk("t5.hold.rd",   32'(ifa.read_S1),  32'd0);
        chk("t5.hold.wr",   32'(ifa.write_S2), 32'd0);
        chk("t5.hold.busy", 32'(busy_a),       32'd1);
        tick();
        cyc_a("t5.emit", 1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1, 20'h40003);
        drive_a(1'b0, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5.busy", 32'(busy_a), 32'd0);
        tick();

        // Reset mid-run while holding {6,0x1234}.
        for (int i = 0; i < 6; i++) begin
            cyc_a("t6.fill", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 20'h0);
        end
        drive_a(1'b1, 16'h1234, 1'b0, 1'b0);
        #1;
        chk("t6.held", 32'(ifa.output_S2), 32'h61234);
        #1;
        rst = 1'b0;
        #1;
        chk("t6.out",  32'(ifa.output_S2), 32'd0);
        chk("t6.wr",   32'(ifa.write_S2),  32'd0);
        chk("t6.rd",   32'(ifa.read_S1),   32'd0);
        chk("t6.busy", 32'(busy_a),        32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b0, 16'd0, 1'b0, 1'b0);
            @(negedge clk);
            chk("t6.quiet.wr",   32'(ifa.write_S2), 32'd0);
            chk("t6.quiet.busy", 32'(busy_a),       32'd0);
            tick();
        end
        cyc_a("t6.new", 1'b1, 16'h0055, 1'b0, 1'b0, 1'b1, 1'b0, 20'h0);
        cyc_a("t6.fl",  1'b0, 16'd0,    1'b1, 1'b0, 1'b0, 1'b1, 20'h10055);
        drive_a(1'b0, 16'd0, 1'b0, 1'b0);

        // Idle timeout of 8 on dut_b: 9,9 then idle; emit 9 cycles after the last read.
        for (int i = 0; i < 2; i++) begin
            ifb.avail_S1 = 1'b1;
            ifb.input_S1 = 16'd9;
            @(negedge clk);
            chk("t4.rd", 32'(ifb.read_S1), 32'd1);
            tick();
        end
        ifb.avail_S1 = 1'b0;
        ifb.input_S1 = 16'd0;
        hit_k = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ifb.write_S2 && hit_k == 0) begin
                hit_k = k;
                chk("t4.out", 32'(ifb.output_S2), 32'h20009);
            end
            tick();
            if (hit_k != 0) break;
        end
        chk("t4.delay", 32'(hit_k), 32'd9);
        @(negedge clk);
        chk("t4.busy", 32'(busy_b), 32'd0);
        chk("t4.wr",   32'(ifb.write_S2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rle_kernel_param.md
Name: rle_kernel_param

Overview:
- Parametrised streaming run-length encoder; successor to the fixed 16-bit RLE kernel.
- Sits between two single-entry or deeper stream FIFOs in the generated fpga top-level.
  - Consumes words from an avail/read input edge.
  - Emits packed {run_count, run_value} words to a write/afull output edge.
- Adds behaviour the previous kernel lacks:
  - configurable data and count widths
  - run-length saturation
  - explicit flush input
  - idle-timeout auto-flush

Parameters:
- DATA_WIDTH, 16, width of input words and of the run_value field.
- COUNT_WIDTH, 8, width of the run_count field; legal range 2..16. MAX_RUN = 2^COUNT_WIDTH - 1.
- IDLE_TIMEOUT, 0, cycles with avail_S1=0 in RUN before the held run is emitted automatically; 0 disables the timeout; legal range 0..65535.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- input_S1  input  DATA_WIDTH  input stream data; valid whenever avail_S1=1
- avail_S1  input  1  input edge holds a word
- read_S1  output  1  consume the word on input_S1 at this rising edge
- flush  input  1  level; request emission of the held run
- output_S2  output  COUNT_WIDTH+DATA_WIDTH  packed {run_count[MSBs], run_value[LSBs]}
- write_S2  output  1  output_S2 is written into the output edge at this rising edge
- afull_S2  input  1  output edge cannot accept a write this cycle
- busy  output  1  a run is held (state != EMPTY)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=EMPTY; run_value=0, run_count=0, idle_cnt=0, flush_pend=0.
  - read_S1=0, write_S2=0, output_S2=0, busy=0.
  - Reset mid-run discards the held run; nothing is emitted.
- Timing of outputs:
  - read_S1 and write_S2 are combinational from registered state, avail_S1, input_S1, flush and afull_S2.
  - output_S2 is always {run_count, run_value} from registers.
  - write_S2 is never 1 while afull_S2=1.
  - read_S1 is never 1 while avail_S1=0.
- States: EMPTY, RUN, FLUSH.
- EMPTY:
  - avail_S1=1: read_S1=1; load run_value=input_S1, run_count=1, idle_cnt=0; go to RUN.
  - flush is ignored in EMPTY. No zero-count word is ever emitted.
- RUN, evaluated in this priority order:
  1. flush=1 or flush_pend=1 or (IDLE_TIMEOUT!=0 and idle_cnt==IDLE_TIMEOUT):
     - If afull_S2=0: write_S2=1, read_S1=0; clear flush_pend and idle_cnt; go to EMPTY.
     - Else: set flush_pend=1, read_S1=0; go to FLUSH.
  2. avail_S1=1, input_S1==run_value, run_count<MAX_RUN: read_S1=1, run_count+1, idle_cnt=0.
  3. avail_S1=1, and input_S1!=run_value or run_count==MAX_RUN:
     - If afull_S2=0: write_S2=1 and read_S1=1 in the same cycle; run_value=input_S1, run_count=1, idle_cnt=0; stay in RUN.
     - Else: read_S1=0, all registers hold (stall).
  4. avail_S1=0: idle_cnt increments and saturates at IDLE_TIMEOUT; write_S2=0.
- FLUSH:
  - read_S1=0.
  - When afull_S2=0: write_S2=1, clear flush_pend; go to EMPTY.
  - flush deassertion does not cancel a pending flush.
- Saturation: a run longer than MAX_RUN is split into a {MAX_RUN, v} word followed by a new run of v starting at 1.
- Throughput: one input word per cycle while unstalled. A run-terminating word is consumed in the same cycle its predecessor run is written.
- busy = (state != EMPTY).

Test Plan:
- Defaults except COUNT_WIDTH=4, IDLE_TIMEOUT=0.
  - Feed 5,5,5,7,7 then flush=1 for 1 cycle, afull_S2=0.
  - Required: writes {3,5} on the cycle 7 is read, then {2,7} on the flush cycle; busy returns 0.
- COUNT_WIDTH=4.
  - Feed 18 consecutive 0x00AA words, then flush.
  - Required: writes {15,0xAA} on the cycle the 16th word is read, then {3,0xAA}.
- Backpressure.
  - Feed 1,2 with afull_S2=1 held for 4 cycles.
  - Required: read_S1=0 on word 2 for 4 cycles, no write, registers stable.
  - After afull drops: {1,1} is written and word 2 is read in the same cycle.
- IDLE_TIMEOUT=8.
  - Feed 9,9 then avail_S1=0.
  - Required: {2,9} is written exactly 9 cycles after the last read (8 counting cycles plus the emit cycle); busy=0 afterwards.
- Flush under afull.
  - In RUN holding {4,3}: pulse flush with afull_S2=1.
  - Required: state FLUSH, read_S1=0 even with avail_S1=1; {4,3} is written on the first cycle afull_S2=0.
- Reset mid-run.
  - Holding {6,0x1234}, assert rst low asynchronously between edges.
  - Required: outputs are 0 immediately; after release, no write occurs until new input arrives.
